// File: rtl/wrr_cfg_pkg.sv
// Shared definitions for the WRR rank-calculator configuration loader:
// CPU index layout, readback field positions, error codes and FSM states.
package wrr_cfg_pkg;

    localparam int PORT_W  = 3;
    localparam int CLASS_W = 5;
    localparam int IDX_W   = PORT_W + CLASS_W;
    localparam int VAL_W   = 27;

    localparam int ROUND_HI = 26;
    localparam int ROUND_LO = 16;
    localparam int CFG_W_HI = 15;
    localparam int CFG_W_LO = 8;
    localparam int CNT_HI   = 7;
    localparam int CNT_LO   = 0;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_GAP,
        RD,
        RD_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/wrr_cfg_loader.sv
// Loads per-class WRR weights for one port over the CPU config bus, then reads
// every class back and verifies the stored weight, reporting mismatch/timeout.
module wrr_cfg_loader
    import wrr_cfg_pkg::*;
#(
    parameter int MAX_CLASSES = 8,
    parameter int GAP_CYCLES  = 1,
    parameter int RD_TIMEOUT  = 16
) (
    input  logic                     clk_cp,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [PORT_W-1:0]        cmd_port,
    input  logic [3:0]               cmd_num_classes,
    input  logic [8*MAX_CLASSES-1:0] cmd_weights,
    output logic                     wire_out_cpu_valid,
    output logic [IDX_W-1:0]         wire_out_cpu_index,
    output logic                     wire_out_cpu_write_sig,
    output logic [8:0]               wire_out_cpu_config_write,
    output logic                     wire_out_cpu_read_sig,
    input  logic                     wire_in_cpu_valid,
    input  logic [IDX_W-1:0]         wire_in_cpu_index,
    input  logic [VAL_W-1:0]         wire_in_cpu_val,
    output logic                     done,
    output logic [1:0]               err_code,
    output logic [CLASS_W-1:0]       err_class
);

    localparam logic [CLASS_W-1:0] MAXC = CLASS_W'(MAX_CLASSES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam int TW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    // Timeout is measured from the read strobe, so done lands RD_TIMEOUT cycles after it.
    localparam logic [TW-1:0] TMO_LAST = TW'((RD_TIMEOUT > 1) ? RD_TIMEOUT - 2 : 0);

    state_e                   state_q;
    logic [PORT_W-1:0]        port_q;
    logic [CLASS_W-1:0]       n_q;
    logic [CLASS_W-1:0]       k_q;
    logic [8*MAX_CLASSES-1:0] weights_q;
    logic [GW-1:0]            gap_q;
    logic [TW-1:0]            tmo_q;
    logic                     ready_q;
    logic                     valid_q;
    logic                     wr_q;
    logic                     rd_q;
    logic [IDX_W-1:0]         idx_q;
    logic [8:0]               cfg_q;
    logic                     done_q;
    logic [1:0]               err_q;
    logic [CLASS_W-1:0]       errc_q;

    logic [CLASS_W-1:0] num_d;
    logic [CLASS_W-1:0] k_inc;
    logic               last_class;
    logic [7:0]         cur_w;
    logic [7:0]         nxt_w;
    logic               rsp_hit;
    logic               wr_advance;
    logic               unused_rsp_fields;

    function automatic logic [7:0] weight_at(input logic [8*MAX_CLASSES-1:0] w,
                                             input logic [CLASS_W-1:0]       k);
        weight_at = 8'h00;
        for (int i = 0; i < MAX_CLASSES; i++)
            if (k == CLASS_W'(i)) weight_at = w[8*i +: 8];
    endfunction

    assign num_d      = ({1'b0, cmd_num_classes} > MAXC) ? MAXC : {1'b0, cmd_num_classes};
    assign k_inc      = k_q + 1'b1;
    assign last_class = (k_q == n_q - 1'b1);
    assign cur_w      = weight_at(weights_q, k_q);
    assign nxt_w      = weight_at(weights_q, k_inc);
    assign rsp_hit    = wire_in_cpu_valid && (wire_in_cpu_index == {port_q, k_q});
    assign wr_advance = (GAP_CYCLES == 0) ? (state_q == WR)
                                          : (state_q == WR_GAP && gap_q == GAP_LAST);

    // Only the stored weight is verified; round and counter are informational.
    assign unused_rsp_fields = ^{wire_in_cpu_val[ROUND_HI:ROUND_LO], wire_in_cpu_val[CNT_HI:CNT_LO]};

    always_ff @(posedge clk_cp or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= '0;
            n_q       <= '0;
            k_q       <= '0;
            weights_q <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
            errc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        port_q    <= cmd_port;
                        n_q       <= num_d;
                        weights_q <= cmd_weights;
                        k_q       <= '0;
                        err_q     <= ERR_OK;
                        errc_q    <= '0;
                        if (num_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WR;
                            valid_q <= 1'b1;
                            wr_q    <= 1'b1;
                            idx_q   <= {cmd_port, CLASS_W'(0)};
                            cfg_q   <= {1'b0, cmd_weights[7:0]};
                        end
                    end
                end
                WR, WR_GAP: begin
                    if (wr_advance) begin
                        if (last_class) begin
                            state_q <= RD;
                            k_q     <= '0;
                            valid_q <= 1'b1;
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                            idx_q   <= {port_q, CLASS_W'(0)};
                            cfg_q   <= '0;
                        end else begin
                            state_q <= WR;
                            k_q     <= k_inc;
                            valid_q <= 1'b1;
                            wr_q    <= 1'b1;
                            idx_q   <= {port_q, k_inc};
                            cfg_q   <= {1'b0, nxt_w};
                        end
                    end else if (state_q == WR) begin
                        state_q <= WR_GAP;
                        gap_q   <= '0;
                        valid_q <= 1'b0;
                        wr_q    <= 1'b0;
                        idx_q   <= '0;
                        cfg_q   <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RD: begin
                    state_q <= RD_WAIT;
                    tmo_q   <= '0;
                    valid_q <= 1'b0;
                    rd_q    <= 1'b0;
                    idx_q   <= '0;
                end
                RD_WAIT: begin
                    if (rsp_hit) begin
                        if (wire_in_cpu_val[CFG_W_HI:CFG_W_LO] != cur_w) begin
                            err_q   <= ERR_MISMATCH;
                            errc_q  <= k_q;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (last_class) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD;
                            k_q     <= k_inc;
                            valid_q <= 1'b1;
                            rd_q    <= 1'b1;
                            idx_q   <= {port_q, k_inc};
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= ERR_TIMEOUT;
                        errc_q  <= k_q;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready                 = ready_q;
    assign wire_out_cpu_valid        = valid_q;
    assign wire_out_cpu_index        = idx_q;
    assign wire_out_cpu_write_sig    = wr_q;
    assign wire_out_cpu_config_write = cfg_q;
    assign wire_out_cpu_read_sig     = rd_q;
    assign done                      = done_q;
    assign err_code                  = err_q;
    assign err_class                 = errc_q;

endmodule

// File: tb/tb_wrr_cfg_loader.sv
// Directed bench for wrr_cfg_loader: write/readback timing, mismatch, timeout,
// empty command, busy hold, clamping, mid-sequence reset and stray responses.
module tb_wrr_cfg_loader;
    import wrr_cfg_pkg::*;

    logic        clk_cp = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_port;
    logic [3:0]  cmd_num_classes;
    logic [63:0] cmd_weights;
    logic        wire_out_cpu_valid;
    logic [7:0]  wire_out_cpu_index;
    logic        wire_out_cpu_write_sig;
    logic [8:0]  wire_out_cpu_config_write;
    logic        wire_out_cpu_read_sig;
    logic        wire_in_cpu_valid;
    logic [7:0]  wire_in_cpu_index;
    logic [26:0] wire_in_cpu_val;
    logic        done;
    logic [1:0]  err_code;
    logic [4:0]  err_class;

    wrr_cfg_loader #(
        .MAX_CLASSES(8),
        .GAP_CYCLES (1),
        .RD_TIMEOUT (16)
    ) dut (
        .clk_cp                   (clk_cp),
        .rst                      (rst),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_port                 (cmd_port),
        .cmd_num_classes          (cmd_num_classes),
        .cmd_weights              (cmd_weights),
        .wire_out_cpu_valid       (wire_out_cpu_valid),
        .wire_out_cpu_index       (wire_out_cpu_index),
        .wire_out_cpu_write_sig   (wire_out_cpu_write_sig),
        .wire_out_cpu_config_write(wire_out_cpu_config_write),
        .wire_out_cpu_read_sig    (wire_out_cpu_read_sig),
        .wire_in_cpu_valid        (wire_in_cpu_valid),
        .wire_in_cpu_index        (wire_in_cpu_index),
        .wire_in_cpu_val          (wire_in_cpu_val),
        .done                     (done),
        .err_code                 (err_code),
        .err_class                (err_class)
    );

    always #5 clk_cp = ~clk_cp;

    int cyc = 0;
    always @(posedge clk_cp) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe log, filled on the falling edge while a command is running.
    int         s_rel[$];
    logic [7:0] s_idx[$];
    logic       s_wr[$];
    logic       s_rd[$];
    logic [8:0] s_cfg[$];
    int         c0 = 0;
    bit         logging = 0;

    always @(negedge clk_cp) begin
        if (logging && wire_out_cpu_valid) begin
            s_rel.push_back(cyc - c0);
            s_idx.push_back(wire_out_cpu_index);
            s_wr.push_back(wire_out_cpu_write_sig);
            s_rd.push_back(wire_out_cpu_read_sig);
            s_cfg.push_back(wire_out_cpu_config_write);
        end
    end

    // Rank-calculator model: 0 echo, 1 bad weight for bad_class, 2 silent, 3 stray index first.
    logic [7:0] model_w [8];
    int         rsp_mode  = 0;
    logic [4:0] bad_class = 5'd0;
    bit         rsp_due = 0;
    bit         rsp_wrong_due = 0;
    logic [7:0] rsp_idx = 8'h00;
    logic [7:0] rsp_wt = 8'h00;

    initial begin
        wire_in_cpu_valid = 1'b0;
        wire_in_cpu_index = 8'h00;
        wire_in_cpu_val   = 27'h0;
        forever begin
            @(negedge clk_cp);
            wire_in_cpu_valid = 1'b0;
            if (rsp_wrong_due) begin
                wire_in_cpu_valid = 1'b1;
                wire_in_cpu_index = {rsp_idx[7:5], rsp_idx[4:0] + 5'd1};
                wire_in_cpu_val   = {11'd3, ~rsp_wt, 8'h5A};
                rsp_wrong_due     = 0;
                rsp_due           = 1;
            end else if (rsp_due) begin
                wire_in_cpu_valid = 1'b1;
                wire_in_cpu_index = rsp_idx;
                wire_in_cpu_val   = {11'd3, rsp_wt, 8'hA5};
                rsp_due           = 0;
            end
            if (!rst && wire_out_cpu_valid && wire_out_cpu_read_sig && rsp_mode != 2) begin
                rsp_idx = wire_out_cpu_index;
                rsp_wt  = model_w[wire_out_cpu_index[2:0]];
                if (rsp_mode == 1 && wire_out_cpu_index[4:0] == bad_class) rsp_wt = 8'd4;
                if (rsp_mode == 3) rsp_wrong_due = 1;
                else rsp_due = 1;
            end
        end
    end

    function automatic logic [63:0] pack_w();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = model_w[k];
        return v;
    endfunction

    task automatic start_cmd(input logic [2:0] p, input logic [3:0] n);
        int guard;
        guard = 0;
        @(negedge clk_cp);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk_cp);
            guard++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        s_rel.delete(); s_idx.delete(); s_wr.delete(); s_rd.delete(); s_cfg.delete();
        c0              = cyc;
        logging         = 1;
        cmd_port        = p;
        cmd_num_classes = n;
        cmd_weights     = pack_w();
        cmd_valid       = 1'b1;
        @(negedge clk_cp);
        cmd_valid = 1'b0;
        check("busy_ready", cmd_ready, 0);
    endtask

    task automatic wait_done(input int exp_rel, input logic [1:0] exp_err, input logic [4:0] exp_cls);
        int guard;
        int rel;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk_cp);
            guard++;
        end
        cmd_valid = 1'b0;
        check("done_seen", done, 1);
        rel = cyc - c0;
        check("done_cycle", rel, exp_rel);
        check("err_code", err_code, exp_err);
        check("err_class", err_class, exp_cls);
        $display("cmd port=%0d n=%0d strobes=%0d done@%0d err=%0d class=%0d",
                 cmd_port, cmd_num_classes, s_rel.size(), rel, err_code, err_class);
        @(negedge clk_cp);
        check("done_one_cycle", done, 0);
        check("ready_after_done", cmd_ready, 1);
        logging = 0;
    endtask

    // Writes expected at 1,3,5,...; reads at rd0 + rd_step*k.
    task automatic check_strobes(input logic [2:0] p, input int nw, input int nr,
                                 input int rd0, input int rd_step);
        bit is_rd;
        int kk;
        check("strobe_count", s_rel.size(), nw + nr);
        for (int k = 0; k < nw + nr && k < s_rel.size(); k++) begin
            is_rd = (k >= nw);
            kk    = is_rd ? k - nw : k;
            check(is_rd ? "rd_cycle" : "wr_cycle", s_rel[k], is_rd ? rd0 + rd_step*kk : 1 + 2*kk);
            check("index", s_idx[k], {p, kk[4:0]});
            check("write_sig", s_wr[k], !is_rd);
            check("read_sig", s_rd[k], is_rd);
            if (!is_rd) check("cfg_write", s_cfg[k], {1'b0, model_w[kk]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_port = 3'd0;
        cmd_num_classes = 4'd0;
        cmd_weights = 64'h0;
        model_w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        repeat (3) @(negedge clk_cp);
        check("rst_ready", cmd_ready, 0);
        check("rst_valid", wire_out_cpu_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_index", wire_out_cpu_index, 0);
        rst = 1'b0;
        @(negedge clk_cp);
        check("ready_after_rst", cmd_ready, 1);

        // Basic load, port 0, weights 5,3,2,1
        rsp_mode = 0;
        model_w  = '{8'd5, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd0, 4'd4);
        wait_done(17, ERR_OK, 5'd0);
        check_strobes(3'd0, 4, 4, 9, 2);

        // Mismatch on class 1 aborts the read of class 2
        rsp_mode  = 1;
        bad_class = 5'd1;
        model_w   = '{8'd9, 8'd7, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd1, 4'd3);
        wait_done(11, ERR_MISMATCH, 5'd1);
        check_strobes(3'd1, 3, 2, 7, 2);

        // Silent responder: timeout 16 cycles after the read strobe at cycle 5
        rsp_mode = 2;
        model_w  = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd2, 4'd2);
        wait_done(21, ERR_TIMEOUT, 5'd0);
        check_strobes(3'd2, 2, 1, 5, 2);

        // Empty command, also clears the previous error
        rsp_mode = 0;
        start_cmd(3'd3, 4'd0);
        wait_done(1, ERR_OK, 5'd0);
        check("empty_strobes", s_rel.size(), 0);

        // A second request held while busy must not be taken
        model_w = '{8'h11, 8'h22, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd3, 4'd2);
        cmd_port        = 3'd5;
        cmd_num_classes = 4'd4;
        cmd_valid       = 1'b1;
        wait_done(9, ERR_OK, 5'd0);
        check_strobes(3'd3, 2, 2, 5, 2);
        @(negedge clk_cp);
        check("held_not_accepted", cmd_ready, 1);

        // Count above MAX_CLASSES clamps to 8
        model_w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        start_cmd(3'd7, 4'd15);
        wait_done(33, ERR_OK, 5'd0);
        check_strobes(3'd7, 8, 8, 17, 2);

        // Reset during the third write
        model_w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd4, 4'd4);
        repeat (4) @(negedge clk_cp);
        check("wr3_valid", wire_out_cpu_valid, 1);
        check("wr3_index", wire_out_cpu_index, 8'h82);
        check("wr3_cfg", wire_out_cpu_config_write, 9'd30);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", wire_out_cpu_valid, 0);
        check("mid_rst_wr", wire_out_cpu_write_sig, 0);
        check("mid_rst_rd", wire_out_cpu_read_sig, 0);
        check("mid_rst_index", wire_out_cpu_index, 0);
        check("mid_rst_cfg", wire_out_cpu_config_write, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", {err_class, err_code}, 0);
        check("mid_rst_ready", cmd_ready, 0);
        $display("reset asserted mid-sequence at cycle %0d", cyc - c0);
        logging = 0;
        @(negedge clk_cp);
        rst = 1'b0;
        @(negedge clk_cp);
        check("ready_after_mid_rst", cmd_ready, 1);
        model_w = '{8'h11, 8'hFE, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd6, 4'd2);
        wait_done(9, ERR_OK, 5'd0);
        check_strobes(3'd6, 2, 2, 5, 2);

        // Stray response with the wrong index precedes each correct one
        rsp_mode = 3;
        model_w  = '{8'h40, 8'h41, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_cmd(3'd5, 4'd2);
        wait_done(11, ERR_OK, 5'd0);
        check_strobes(3'd5, 2, 2, 5, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
